// File: rtl/hero_pkg.sv
// Shared constants for the hero movement slice: direction codes, screen
// dimensions and coordinate widths.
package hero_pkg;

  // Direction codes produced by the direction-state stage
  localparam logic [1:0] DIR_UP    = 2'b00;  // y decreases
  localparam logic [1:0] DIR_DOWN  = 2'b01;  // y increases
  localparam logic [1:0] DIR_LEFT  = 2'b10;  // x decreases
  localparam logic [1:0] DIR_RIGHT = 2'b11;  // x increases

  // Visible screen area in pixels
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Coordinate register widths
  localparam int X_W = 10;
  localparam int Y_W = 9;

endpackage

// File: rtl/hero_tick_div.sv
// Movement tick generator: counts 0..TICK_DIV-1 and wraps, with tick high
// while the count sits at TICK_DIV-1. A clear restarts the count at 0 so a
// direction change always gets a full tick period before its first step.
module hero_tick_div #(
  parameter int TICK_DIV = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running divider; clear and terminal count both return to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hero_motion.sv
// Hero position / walk animation. Steps STEP pixels in the current direction
// once per movement tick while a button is held. Step arithmetic is done one
// bit wider than the coordinate, so an underflow below 0 shows up as a huge
// value and a single "> MAX" compare catches both edges.
// Build option: define HERO_WRAP_EN to wrap off-screen steps to the opposite
// edge instead of blocking them (hit_wall then never pulses).
module hero_motion
  import hero_pkg::*;
#(
  parameter int TICK_DIV = 2_500_000,
  parameter int STEP     = 4,
  parameter int X_MAX    = SCREEN_W - 1,
  parameter int Y_MAX    = SCREEN_H - 1,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     dir,
  input  logic [1:0]     old_dir,
  input  logic           move,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     anim_frame,
  output logic           moving,
  output logic           hit_wall
);

  localparam logic [X_W:0] X_MAX_E  = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0] Y_MAX_E  = (Y_W+1)'(Y_MAX);
  localparam logic [X_W:0] X_SPAN_E = (X_W+1)'(X_MAX + 1);
  localparam logic [Y_W:0] Y_SPAN_E = (Y_W+1)'(Y_MAX + 1);
  localparam logic [X_W:0] STEP_X   = (X_W+1)'(STEP);
  localparam logic [Y_W:0] STEP_Y   = (Y_W+1)'(STEP);

  logic           tick;
  logic           dir_change;
  logic [X_W:0]   x_inc, x_dec, x_try;
  logic [Y_W:0]   y_inc, y_dec, y_try;
  logic           out_of_range;
  logic           blocked;

  assign dir_change = (dir != old_dir);

  hero_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (dir_change),
    .tick  (tick)
  );

  assign x_inc = {1'b0, x} + STEP_X;
  assign x_dec = {1'b0, x} - STEP_X;
  assign y_inc = {1'b0, y} + STEP_Y;
  assign y_dec = {1'b0, y} - STEP_Y;

  // Candidate position for a step in dir, plus whether it leaves the screen
  always_comb begin
    x_try        = {1'b0, x};
    y_try        = {1'b0, y};
    out_of_range = 1'b0;
    case (dir)
      DIR_UP: begin
        out_of_range = (y_dec > Y_MAX_E);
        y_try        = out_of_range ? (y_dec + Y_SPAN_E) : y_dec;
      end
      DIR_DOWN: begin
        out_of_range = (y_inc > Y_MAX_E);
        y_try        = out_of_range ? (y_inc - Y_SPAN_E) : y_inc;
      end
      DIR_LEFT: begin
        out_of_range = (x_dec > X_MAX_E);
        x_try        = out_of_range ? (x_dec + X_SPAN_E) : x_dec;
      end
      default: begin
        out_of_range = (x_inc > X_MAX_E);
        x_try        = out_of_range ? (x_inc - X_SPAN_E) : x_inc;
      end
    endcase
  end

`ifdef HERO_WRAP_EN
  // Wrapped position is always legal, so no step is ever refused
  assign blocked = 1'b0;
`else
  assign blocked = out_of_range;
`endif

  // Position, animation and status update; only ticks advance the hero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= X_W'(X_INIT);
      y          <= Y_W'(Y_INIT);
      anim_frame <= 2'd0;
      moving     <= 1'b0;
      hit_wall   <= 1'b0;
    end else begin
      hit_wall <= 1'b0;
      if (dir_change) begin
        // Turning restarts the walk cycle; a coinciding tick takes no step
        anim_frame <= 2'd0;
        if (tick) moving <= 1'b0;
      end else if (tick) begin
        if (!move) begin
          moving <= 1'b0;
        end else if (blocked) begin
          hit_wall <= 1'b1;
          moving   <= 1'b0;
        end else begin
          x          <= x_try[X_W-1:0];
          y          <= y_try[Y_W-1:0];
          anim_frame <= anim_frame + 2'd1;
          moving     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hero_motion.sv
// Directed bench for hero_motion with TICK_DIV=4, STEP=4, 640x480 screen.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Define HERO_WRAP_EN for both RTL and bench to check the wrapping build.
module tb_hero_motion;

  logic       clk;
  logic       rst_n;
  logic [1:0] dir;
  logic [1:0] old_dir;
  logic       move;
  logic [9:0] x;
  logic [8:0] y;
  logic [1:0] anim_frame;
  logic       moving;
  logic       hit_wall;

  int errors;
  int checks;

  typedef struct {
    logic [1:0] dir;
    logic [1:0] old_dir;
    logic       move;
    int         ncyc;
    int         ex;
    int         ey;
    int         ea;
    int         em;
    int         eh;
  } vec_t;

  vec_t tbl[$];

  hero_motion #(
    .TICK_DIV (4),
    .STEP     (4),
    .X_MAX    (639),
    .Y_MAX    (479),
    .X_INIT   (320),
    .Y_INIT   (240)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dir        (dir),
    .old_dir    (old_dir),
    .move       (move),
    .x          (x),
    .y          (y),
    .anim_frame (anim_frame),
    .moving     (moving),
    .hit_wall   (hit_wall)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ex, input int ey,
                           input int ea, input int em, input int eh);
    chk({tag, ".x"}, int'(x), ex);
    chk({tag, ".y"}, int'(y), ey);
    chk({tag, ".anim"}, int'(anim_frame), ea);
    chk({tag, ".moving"}, int'(moving), em);
    chk({tag, ".hit_wall"}, int'(hit_wall), eh);
  endtask

  task automatic add_vec(input logic [1:0] d, input logic [1:0] od, input logic mv,
                         input int n, input int ex, input int ey, input int ea,
                         input int em, input int eh);
    vec_t v;
    v.dir = d; v.old_dir = od; v.move = mv; v.ncyc = n;
    v.ex = ex; v.ey = ey; v.ea = ea; v.em = em; v.eh = eh;
    tbl.push_back(v);
  endtask

`ifdef HERO_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  initial begin
    errors = 0;
    checks = 0;

    // Vectors continue one after another from reset release (counter at 0)
    //      dir   old   mv  cyc   x    y   anim mov hit
    add_vec(2'd3, 2'd3, 1, 3, 320, 240, 0, 0, 0);  // counter reaches 3, no step yet
    add_vec(2'd3, 2'd3, 1, 1, 324, 240, 1, 1, 0);  // first tick
    add_vec(2'd3, 2'd3, 1, 4, 328, 240, 2, 1, 0);  // second tick
    add_vec(2'd3, 2'd3, 0, 4, 328, 240, 2, 0, 0);  // move=0 tick 1
    add_vec(2'd3, 2'd3, 0, 4, 328, 240, 2, 0, 0);  // move=0 tick 2
    add_vec(2'd3, 2'd3, 0, 4, 328, 240, 2, 0, 0);  // move=0 tick 3
    add_vec(2'd3, 2'd3, 1, 3, 328, 240, 2, 0, 0);  // one short of a tick
    add_vec(2'd0, 2'd3, 1, 1, 328, 240, 0, 0, 0);  // turn on the tick: no step
    add_vec(2'd0, 2'd0, 1, 3, 328, 240, 0, 0, 0);  // counter restarted
    add_vec(2'd0, 2'd0, 1, 1, 328, 236, 1, 1, 0);  // step 1 up
    add_vec(2'd0, 2'd0, 1, 2, 328, 236, 1, 1, 0);  // moving holds between ticks
    add_vec(2'd0, 2'd0, 1, 2, 328, 232, 2, 1, 0);  // step 2
    add_vec(2'd0, 2'd0, 1, 4, 328, 228, 3, 1, 0);  // step 3
    add_vec(2'd0, 2'd0, 1, 4, 328, 224, 0, 1, 0);  // step 4, frame wraps
    add_vec(2'd0, 2'd0, 1, 4, 328, 220, 1, 1, 0);  // step 5

    // Reset block
    rst_n   = 1'b0;
    dir     = 2'd3;
    old_dir = 2'd3;
    move    = 1'b1;
    #12;
    check_all("reset", 320, 240, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      dir     = tbl[i].dir;
      old_dir = tbl[i].old_dir;
      move    = tbl[i].move;
      wait_cyc(tbl[i].ncyc);
      check_all($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ea,
                tbl[i].em, tbl[i].eh);
    end

    // Walk right to the last legal x, then step into the right edge
    dir = 2'd3; old_dir = 2'd0; move = 1'b1;
    wait_cyc(1);
    old_dir = 2'd3;
    wait_cyc(77 * 4);
    check_all("walk_right", 636, 220, 1, 1, 0);
    wait_cyc(3);
    chk("pre_edge.hit_wall", int'(hit_wall), 0);
    wait_cyc(1);
    if (WRAP) check_all("edge_right", 0, 220, 2, 1, 0);
    else      check_all("edge_right", 636, 220, 1, 0, 1);
    wait_cyc(1);
    chk("edge_right_next.hit_wall", int'(hit_wall), 0);
    chk("edge_right_next.x", int'(x), WRAP ? 0 : 636);

    // Walk up to y=0, then step past the top (underflow in wide arithmetic)
    dir = 2'd0; old_dir = 2'd3;
    wait_cyc(1);
    old_dir = 2'd0;
    wait_cyc(55 * 4);
    check_all("walk_up", WRAP ? 0 : 636, 0, 3, 1, 0);
    wait_cyc(4);
    if (WRAP) check_all("edge_top", 0, 476, 0, 1, 0);
    else      check_all("edge_top", 636, 0, 3, 0, 1);

    // Three steps left, then reset with the counter at 2
    dir = 2'd2; old_dir = 2'd0;
    wait_cyc(1);
    old_dir = 2'd2;
    wait_cyc(12);
    check_all("walk_left", WRAP ? 628 : 624, WRAP ? 476 : 0, 3, 1, 0);
    wait_cyc(2);
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 320, 240, 0, 0, 0);
    wait_cyc(2);
    check_all("in_reset", 320, 240, 0, 0, 0);
    rst_n = 1'b1;
    wait_cyc(3);
    check_all("post_reset_wait", 320, 240, 0, 0, 0);
    wait_cyc(1);
    check_all("post_reset_tick", 316, 240, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
